// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader: framed byte stream -> little-endian 32-bit I-MEM writes, with
// checksum verification and core-reset gating.   Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0] STEP     = ADDR_STEP[31:0];

    state_t        state;
    logic [7:0]    len_lo;
    logic [15:0]   n_len;
    logic [1:0]    byte_idx;
    logic [23:0]   shift_word;
    logic [7:0]    csum;
    logic [TW-1:0] tmo_cnt;

    logic        accept;
    logic [15:0] len_full;
    assign accept   = rx_valid && rx_ready;
    assign len_full = {rx_data, len_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'h0;
            core_rst_n <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 16'h0;
            len_lo     <= 8'h0;
            n_len      <= 16'h0;
            byte_idx   <= 2'd0;
            shift_word <= 24'h0;
            csum       <= 8'h0;
            tmo_cnt    <= '0;
        end else if (busy && !accept && tmo_cnt == TMO_LAST) begin
            // Link went silent mid-frame; a coincident start is deliberately lost.
            state      <= S_ERR;
            error      <= 1'b1;
            busy       <= 1'b0;
            core_rst_n <= 1'b0;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            if (accept)
                tmo_cnt <= '0;
            else if (busy)
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN0;
                        busy       <= 1'b1;
                        core_rst_n <= 1'b0;
                        rx_ready   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= 16'h0;
                        byte_idx   <= 2'd0;
                        csum       <= 8'h0;
                        mem_addr   <= BASE_ADDR;
                        tmo_cnt    <= '0;
                    end
                end
                S_LEN0: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (accept) begin
                        n_len <= len_full;
                        if (len_full == 16'h0) begin
                            state <= S_CSUM;
                        end else if (32'(len_full) > DEPTH) begin
                            state      <= S_ERR;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            rx_ready   <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (mem_we) begin
                        // Strobe cycle: advance address/count and reopen the link.
                        mem_we     <= 1'b0;
                        mem_addr   <= mem_addr + STEP;
                        word_count <= word_count + 16'd1;
                        rx_ready   <= 1'b1;
                        if (word_count + 16'd1 == n_len)
                            state <= S_CSUM;
                    end else if (accept) begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {rx_data, shift_word};
                            mem_we    <= 1'b1;
                            rx_ready  <= 1'b0;
                        end else begin
                            shift_word[{byte_idx, 3'b000} +: 8] <= rx_data;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        busy     <= 1'b0;
                        rx_ready <= 1'b0;
                        if (csum == rx_data) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
